vga_fb_arbiter: RTL and testbench

//  Shares the single-port framebuffer RAM between the CPU and VGA scanline prefetch.
//  On each line_start during vlookahead, fetches WORDS_PER_LINE words for row y into a ping-pong line buffer.

---
 rtl/vga_fb_arbiter_pkg.sv | 17 +
 rtl/vga_fb_fetch_addr.sv | 44 ++++
 rtl/vga_fb_arbiter.sv | 153 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter: FSM encoding, default
// geometry of the scanline prefetch, and the line-buffer depth.
package vga_fb_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CPU_ISSUE,
    CPU_DONE,
    FETCH,
    DRAIN
  } state_t;

  localparam int          WPL_DEFAULT     = 40;
  localparam logic [15:0] FB_BASE_DEFAULT = 16'h8000;
  localparam int          LB_AW_DEFAULT   = 6;
  localparam int          LB_DEPTH        = 1 << LB_AW_DEFAULT;
  localparam int          Y_W             = 10;
endpackage

// File: rtl/vga_fb_fetch_addr.sv
// Row base multiply-add and word counter for the scanline fetch.
//  row_sel   : row whose base is used for the next issued address
//  start     : next issued word is word 0 (new or restarted fetch)
//  advance   : next issued word is word+1
//  word      : index of the word currently on the RAM address bus
//  last      : word is the final word of the line
//  next_addr : RAM address of the next word to issue
module vga_fb_fetch_addr
  import vga_fb_arbiter_pkg::*;
#(
  parameter int                ADDR_W         = 16,
  parameter int                WORDS_PER_LINE = WPL_DEFAULT,
  parameter logic [ADDR_W-1:0] FB_BASE        = FB_BASE_DEFAULT,
  parameter int                LB_AW          = LB_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [Y_W-1:0]    row_sel,
  input  logic              start,
  input  logic              advance,
  output logic [LB_AW-1:0]  word,
  output logic              last,
  output logic [ADDR_W-1:0] next_addr
);
  localparam logic [ADDR_W-1:0] WPL_A = ADDR_W'(WORDS_PER_LINE);

  logic [ADDR_W-1:0] base;
  logic [LB_AW-1:0]  next_word;

  // All arithmetic in ADDR_W bits so the row base wraps mod 2^ADDR_W.
  always_comb begin
    base      = FB_BASE + ADDR_W'(row_sel) * WPL_A;
    next_word = start ? '0 : word + LB_AW'(1);
    next_addr = base + ADDR_W'(next_word);
  end

  assign last = (word == LB_AW'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (!rst)         word <= '0;
    else if (start)   word <= '0;
    else if (advance) word <= word + LB_AW'(1);
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: CPU accesses vs. VGA scanline prefetch into a
// ping-pong line buffer (bank = row parity). Fetch has priority; the CPU
// is granted only when no fetch is pending or active.
//  clk/rst             : clock, synchronous active-low reset
//  line_start/vlookahead/y : prefetch trigger and row from the VGA timing
//  cpu_*               : CPU request/ack bus (2-cycle access from grant)
//  mem_*               : single-port RAM, 1-cycle read latency
//  lb_*                : line-buffer write port
//  fetch_busy/underrun : status
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 16,
  parameter int                WORDS_PER_LINE = WPL_DEFAULT,
  parameter logic [ADDR_W-1:0] FB_BASE        = FB_BASE_DEFAULT,
  parameter int                LB_AW          = LB_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic              vlookahead,
  input  logic [Y_W-1:0]    y,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [LB_AW-1:0]  lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              underrun
);
  state_t            state;
  logic              pending;
  logic [Y_W-1:0]    row;
  logic              bank;

  logic              trigger, in_fetch, underrun_ev, start, advance;
  logic [Y_W-1:0]    row_sel;
  logic [LB_AW-1:0]  word;
  logic              last;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    trigger     = line_start & vlookahead;
    in_fetch    = (state == FETCH) || (state == DRAIN);
    underrun_ev = trigger && (in_fetch || pending);
    // A trigger seen this cycle supplies the row directly so the first
    // address goes out without waiting for the row latch.
    row_sel     = trigger ? y : row;
    start       = ((state == IDLE) && (pending || trigger)) || (in_fetch && trigger);
    advance     = (state == FETCH) && !trigger && !last;
  end

  vga_fb_fetch_addr #(
    .ADDR_W(ADDR_W), .WORDS_PER_LINE(WORDS_PER_LINE),
    .FB_BASE(FB_BASE), .LB_AW(LB_AW)
  ) u_addr (
    .clk(clk), .rst(rst), .row_sel(row_sel), .start(start), .advance(advance),
    .word(word), .last(last), .next_addr(next_addr)
  );

  // Read data is only meaningful in its strobe cycle; gate it so every
  // output is zero in reset and idle.
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign lb_wdata  = lb_we   ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      row        <= '0;
      bank       <= 1'b0;
      cpu_ack    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      lb_we      <= 1'b0;
      lb_bank    <= 1'b0;
      lb_addr    <= '0;
      fetch_busy <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      mem_we   <= 1'b0;
      lb_we    <= 1'b0;
      underrun <= underrun_ev;
      if (trigger) begin
        row  <= y;
        bank <= y[0];
      end
      case (state)
        IDLE: begin
          if (pending || trigger) begin
            state      <= FETCH;
            pending    <= 1'b0;
            mem_addr   <= next_addr;
            fetch_busy <= 1'b1;
          end else if (cpu_req) begin
            state      <= CPU_ISSUE;
            mem_addr   <= cpu_addr;
            mem_we     <= cpu_we;
            mem_wdata  <= cpu_wdata;
            fetch_busy <= 1'b0;
          end else begin
            fetch_busy <= 1'b0;
          end
        end
        CPU_ISSUE: begin
          if (trigger) pending <= 1'b1;
          fetch_busy <= pending || trigger;
          cpu_ack    <= 1'b1;
          state      <= CPU_DONE;
        end
        CPU_DONE: begin
          if (trigger) pending <= 1'b1;
          fetch_busy <= pending || trigger;
          state      <= IDLE;
        end
        FETCH: begin
          // On restart the word in flight belongs to the abandoned row:
          // drop its write rather than let it land anywhere.
          lb_we      <= !underrun_ev;
          lb_addr    <= word;
          lb_bank    <= bank;
          fetch_busy <= 1'b1;
          if (underrun_ev)  mem_addr <= next_addr;
          else if (last)    state    <= DRAIN;
          else              mem_addr <= next_addr;
        end
        DRAIN: begin
          if (underrun_ev) begin
            state      <= FETCH;
            mem_addr   <= next_addr;
            fetch_busy <= 1'b1;
          end else begin
            state      <= IDLE;
            fetch_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  logic        clk, rst;
  logic        line_start, vlookahead;
  logic [9:0]  y;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic        lb_we, lb_bank;
  logic [5:0]  lb_addr;
  logic [15:0] lb_wdata;
  logic        fetch_busy, underrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] ram [0:65535];

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .line_start(line_start), .vlookahead(vlookahead), .y(y),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .fetch_busy(fetch_busy), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: synchronous write, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered in the cycle that shows word 0 on mem_addr; leaves in the IDLE
  // cycle after DRAIN.
  task automatic run_fetch(input logic [15:0] base, input logic bnk);
    for (int k = 0; k < 40; k++) begin
      chk("fetch_addr", mem_addr, base + 16'(k));
      chk("fetch_we0", mem_we, 0);
      chk("fetch_ack0", cpu_ack, 0);
      if (k > 0) begin
        chk("lb_we", lb_we, 1);
        chk("lb_addr", lb_addr, k - 1);
        chk("lb_bank", lb_bank, bnk);
        chk("lb_wdata", lb_wdata, pat(base + 16'(k - 1)));
      end
      if (k == 1) chk("underrun_clear", underrun, 0);
      tick();
    end
    chk("drain_lb_we", lb_we, 1);
    chk("drain_lb_addr", lb_addr, 39);
    chk("drain_lb_wdata", lb_wdata, pat(base + 16'd39));
    chk("drain_busy", fetch_busy, 1);
    tick();
    chk("idle_lb_we", lb_we, 0);
    chk("idle_busy", fetch_busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
    rst = 1'b0; line_start = 0; vlookahead = 0; y = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick(); tick();

    // reset state
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_lb_we", lb_we, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_lb_wdata", lb_wdata, 0);
    rst = 1'b1;
    tick();

    // 1: y=0 fetch on idle RAM
    line_start = 1; vlookahead = 1; y = 10'd0;
    tick();
    line_start = 0;
    run_fetch(16'h8000, 1'b0);

    // 2: CPU read while idle
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    tick();
    chk("cpu_issue_addr", mem_addr, 16'h1234);
    chk("cpu_issue_we", mem_we, 0);
    chk("cpu_issue_ack", cpu_ack, 0);
    tick();
    chk("cpu_done_ack", cpu_ack, 1);
    chk("cpu_rdata", cpu_rdata, 16'h486E);
    cpu_req = 0;
    tick();
    chk("cpu_ack_pulse", cpu_ack, 0);

    // 3: trigger together with cpu_req: fetch wins
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    line_start = 1; y = 10'd2;
    tick();
    line_start = 0;
    chk("t3_busy", fetch_busy, 1);
    run_fetch(16'h8050, 1'b0);
    chk("t3_ack_wait", cpu_ack, 0);
    tick();
    chk("t3_issue_addr", mem_addr, 16'h0100);
    tick();
    chk("t3_ack", cpu_ack, 1);
    chk("t3_rdata", cpu_rdata, 16'h5B5A);
    cpu_req = 0;
    tick();

    // 4: trigger during a CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_wdata = 16'hBEEF;
    tick();
    chk("t4_we", mem_we, 1);
    chk("t4_addr", mem_addr, 16'h2000);
    chk("t4_wdata", mem_wdata, 16'hBEEF);
    line_start = 1; y = 10'd1;
    tick();
    line_start = 0; cpu_req = 0; cpu_we = 0;
    chk("t4_ack", cpu_ack, 1);
    chk("t4_we_off", mem_we, 0);
    chk("t4_pending_busy", fetch_busy, 1);
    tick();
    chk("t4_idle_busy", fetch_busy, 1);
    tick();
    run_fetch(16'h8028, 1'b1);
    cpu_req = 1; cpu_addr = 16'h2000;
    tick(); tick();
    chk("t4_readback", cpu_rdata, 16'hBEEF);
    cpu_req = 0;
    tick();

    // 5: y=479, odd bank, underrun at word 20
    line_start = 1; y = 10'd479;
    tick();
    line_start = 0;
    chk("t5_base", mem_addr, 16'hCAD8);
    for (int k = 1; k <= 20; k++) tick();
    chk("t5_word20", mem_addr, 16'hCAEC);
    chk("t5_lb_addr19", lb_addr, 19);
    chk("t5_lb_bank", lb_bank, 1);
    line_start = 1; y = 10'd5;
    tick();
    line_start = 0;
    chk("t5_underrun", underrun, 1);
    chk("t5_no_stale", lb_we, 0);
    run_fetch(16'h80C8, 1'b1);

    // 6: reset during fetch word 10
    line_start = 1; y = 10'd3;
    tick();
    line_start = 0;
    for (int k = 1; k <= 10; k++) tick();
    chk("t6_word10", mem_addr, 16'h8082);
    rst = 1'b0;
    tick();
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_lb_we", lb_we, 0);
    chk("t6_lb_addr", lb_addr, 0);
    chk("t6_busy", fetch_busy, 0);
    chk("t6_lb_wdata", lb_wdata, 0);
    rst = 1'b1;
    tick();
    line_start = 1; y = 10'd4;
    tick();
    line_start = 0;
    run_fetch(16'h80A0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
